execute_muldiv: RTL
===================

# execute_muldiv

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the decode/execute pipeline register. It consumes the E-stage operation (funct3, forwarded operands, destination register) when the E-stage instruction is an M-extension op. It computes the result over multiple cycles with a shift-add multiplier and a restoring divider. It raises a stall to the hazard unit so the E stage holds until the result is ready for the E/M register.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  core clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- start  in  1  E-stage instruction is an M op: opcodeE==7'b0110011 and InstrE[31:25]==7'b0000001.
- flush  in  1  E-stage flush, the same signal that clears the D/E register. Has priority over start.
- funct3E  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcAE  in  32  rs1 value after forwarding.
- SrcBE  in  32  rs2 value after forwarding.
- RdE  in  5  destination register.
- stall_o  out  1  freeze the PC, F/D and D/E registers; E stage holds.
- done_o  out  1  result valid this cycle; E/M register captures it.
- result_o  out  32  operation result.
- rd_o  out  5  destination register latched at accept.

## Operation
- States: IDLE, BUSY, DONE.
- Reset: state=IDLE, counter=0, all operand/accumulator registers 0, result_o=0, done_o=0, rd_o=0.
- **IDLE**
  - If start && !flush: latch funct3, rd, |A|, |B| and result sign; counter=0.
  - Divide special cases go directly to DONE. All other ops go to BUSY.
- **Signedness**
  - A is signed for MULH, MULHSU, DIV, REM. B is signed for MULH, DIV, REM.
  - Magnitudes are taken before iterating; the sign is applied on the final result.
  - MUL uses the signed path; its low 32 bits are identical either way.
- **Multiply** (BUSY, 32 iterations)
  - 64-bit product accumulator: each cycle add |A|<<i if |B| bit i is set.
  - After the last iteration, negate the 64-bit product if the result sign is 1.
  - MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
- **Divide** (BUSY, 32 iterations, restoring, MSB first)
  - Remainder is 33 bits wide.
  - Each cycle: rem = {rem, dividend bit}; if rem >= |B|, subtract |B| and set the quotient bit.
  - Quotient sign = signA ^ signB. Remainder sign = signA.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- **Divide special cases** (resolved in IDLE)
  - B==0: quotient 0xFFFFFFFF; remainder = A unmodified.
  - DIV/REM with A==0x80000000 and B==0xFFFFFFFF: quotient 0x80000000, remainder 0.
- **BUSY**: counter increments each cycle. The cycle counter reaches 31 is the last iteration, and the next state is DONE.
- **DONE**: done_o=1 and result_o is valid. Next state is IDLE unconditionally; back-to-back M ops restart from IDLE.
- **Flush**
  - In any state, flush forces IDLE at the next edge. done_o is 0 in that next cycle and the result is discarded.
  - result_o holds its last value.
- **Reset mid-operation**: immediately returns all outputs to their reset values.

## Timing
- Cycle 0 is the cycle start is first seen in IDLE.
- Normal op:
  - Cycles 1–32 are BUSY; DONE at cycle 33.
  - stall_o=1 in cycles 0–32 and 0 in cycle 33, so the E/M register captures the result at the end of cycle 33.
- Special-case divide: DONE at cycle 1; stall_o=1 in cycle 0 only.
- stall_o = (state==IDLE && start && !flush) || state==BUSY. It is combinational from start/flush and never asserted in DONE.
- done_o and result_o are registered, valid exactly one cycle per completed op.
- start is ignored outside IDLE. The operands latched at accept are used, and input changes during BUSY have no effect.

## Test plan
- MUL, SrcA=7, SrcB=0xFFFFFFFD (−3) → result 0xFFFFFFEB; done_o in cycle 33; stall_o high in cycles 0–32.
- MULH/MULHSU/MULHU, SrcA=SrcB=0x80000000:
  - MULH → 0x40000000.
  - MULHU → 0x40000000.
  - MULHSU → 0xC0000000.
- DIV/REM, SrcA=0xFFFFFFF9 (−7), SrcB=2 → DIV 0xFFFFFFFD (−3), REM 0xFFFFFFFF (−1). DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
- DIVU with B=0, A=0x1234 → 0xFFFFFFFF and REMU → 0x1234, both done in cycle 1. DIV 0x80000000/0xFFFFFFFF → 0x80000000, and REM → 0.
- Flush at cycle 10 of a DIV → IDLE at cycle 11, stall_o=0, no done_o pulse. A new MUL started at cycle 12 completes correctly at cycle 45.
- Deassert n_rst during BUSY → result_o=0, done_o=0, rd_o=0, stall_o=0 immediately. After release, back-to-back MUL then DIVU both produce correct results with no lost op.

Source files
------------

// File: rtl/execute_muldiv_if.sv
// execute_muldiv_if
// Handshake and data bundle between the execute stage and the iterative
// RV32M multiply/divide unit.
//   master : E-stage side. Drives start/flush/op/operands/rd and receives
//            stall/done/result/rd back.
//   slave  : execute_muldiv side.
// Signals:
//   start    M-extension op is present in E
//   flush    E-stage flush, same signal that clears the D/E register
//   funct3E  operation select (MUL..REMU)
//   SrcAE    rs1 after forwarding
//   SrcBE    rs2 after forwarding
//   RdE      destination register
//   stall_o  hold PC, F/D, D/E while the unit is working
//   done_o   result valid this cycle
//   result_o operation result
//   rd_o     destination register latched when the op was accepted
interface execute_muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      funct3E;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic [4:0]      RdE;
    logic            stall_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_o;

    modport master (
        output start, flush, funct3E, SrcAE, SrcBE, RdE,
        input  stall_o, done_o, result_o, rd_o
    );

    modport slave (
        input  start, flush, funct3E, SrcAE, SrcBE, RdE,
        output stall_o, done_o, result_o, rd_o
    );
endinterface

// File: rtl/execute_muldiv.sv
// execute_muldiv
// Iterative RV32M multiply/divide unit in the execute stage. Multiplies with
// a 32-step shift-add loop and divides with a 32-step restoring divider,
// both on operand magnitudes; the sign is applied to the final result.
// Divide-by-zero and signed overflow are resolved in a single cycle.
// Ports:
//   clk    core clock, rising edge
//   n_rst  asynchronous active-low reset
//   bus    execute_muldiv_if.slave (op request in, stall/done/result out)
//
// state | meaning
// IDLE  | waiting for an M op; stall raised combinationally on accept
// BUSY  | 32 multiply or divide iterations, counter 0..31
// DONE  | done_o/result_o valid for one cycle, stall released
module execute_muldiv (
    input  logic           clk,
    input  logic           n_rst,
    execute_muldiv_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q,  state_d;
    logic [4:0]  cnt_q,    cnt_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [4:0]  rd_q,     rd_d;
    logic [31:0] a_q,      a_d;
    logic [31:0] b_q,      b_d;
    logic        neg_q,    neg_d;
    logic        sign_a_q, sign_a_d;
    logic [63:0] acc_q,    acc_d;
    logic [32:0] rem_q,    rem_d;
    logic [31:0] quo_q,    quo_d;
    logic [31:0] result_q, result_d;
    logic        done_q,   done_d;

    logic        in_div;
    logic        in_sa;
    logic        in_sb;
    logic        in_sign_a;
    logic        in_sign_b;
    logic [31:0] in_abs_a;
    logic [31:0] in_abs_b;
    logic        in_div_zero;
    logic        in_div_ovf;

    logic [63:0] prod_next;
    logic [63:0] prod_final;
    logic [32:0] rem_shift;
    logic [32:0] rem_next;
    logic        q_bit;
    logic [31:0] quo_next;
    logic [31:0] quo_final;
    logic [31:0] rem_final;
    logic [31:0] op_result;

    // Operand signedness: MUL rides the signed path since its low half is
    // the same either way.
    always_comb begin
        in_div      = bus.funct3E[2];
        in_sa       = in_div ? ~bus.funct3E[0] : (bus.funct3E[1:0] != 2'b11);
        in_sb       = in_div ? ~bus.funct3E[0] : ~bus.funct3E[1];
        in_sign_a   = in_sa & bus.SrcAE[31];
        in_sign_b   = in_sb & bus.SrcBE[31];
        in_abs_a    = in_sign_a ? (32'd0 - bus.SrcAE) : bus.SrcAE;
        in_abs_b    = in_sign_b ? (32'd0 - bus.SrcBE) : bus.SrcBE;
        in_div_zero = (bus.SrcBE == 32'd0);
        in_div_ovf  = ~bus.funct3E[0] && (bus.SrcAE == 32'h8000_0000) &&
                      (bus.SrcBE == 32'hFFFF_FFFF);
    end

    // One iteration of each datapath; only the one matching funct3_q is
    // committed to the result.
    always_comb begin
        prod_next  = acc_q + (b_q[cnt_q] ? ({32'd0, a_q} << cnt_q) : 64'd0);
        prod_final = neg_q ? (64'd0 - prod_next) : prod_next;
        // a_q is shifted left each divide step, so its MSB is the next
        // dividend bit.
        rem_shift  = (rem_q << 1) | {32'd0, a_q[31]};
        q_bit      = (rem_shift >= {1'b0, b_q});
        rem_next   = q_bit ? (rem_shift - {1'b0, b_q}) : rem_shift;
        quo_next   = {quo_q[30:0], q_bit};
        quo_final  = neg_q ? (32'd0 - quo_next) : quo_next;
        rem_final  = sign_a_q ? (32'd0 - rem_next[31:0]) : rem_next[31:0];
        if (funct3_q[2]) begin
            op_result = funct3_q[1] ? rem_final : quo_final;
        end else begin
            op_result = (funct3_q[1:0] == 2'b00) ? prod_final[31:0] : prod_final[63:32];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        rd_d     = rd_q;
        a_d      = a_q;
        b_d      = b_q;
        neg_d    = neg_q;
        sign_a_d = sign_a_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;
        done_d   = 1'b0;

        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        funct3_d = bus.funct3E;
                        rd_d     = bus.RdE;
                        a_d      = in_abs_a;
                        b_d      = in_abs_b;
                        neg_d    = in_sign_a ^ in_sign_b;
                        sign_a_d = in_sign_a;
                        cnt_d    = 5'd0;
                        acc_d    = 64'd0;
                        rem_d    = 33'd0;
                        quo_d    = 32'd0;
                        if (in_div && in_div_zero) begin
                            state_d  = DONE;
                            done_d   = 1'b1;
                            result_d = bus.funct3E[1] ? bus.SrcAE : 32'hFFFF_FFFF;
                        end else if (in_div && in_div_ovf) begin
                            state_d  = DONE;
                            done_d   = 1'b1;
                            result_d = bus.funct3E[1] ? 32'd0 : 32'h8000_0000;
                        end else begin
                            state_d = BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt_d = cnt_q + 5'd1;
                    acc_d = prod_next;
                    rem_d = rem_next;
                    quo_d = quo_next;
                    a_d   = funct3_q[2] ? {a_q[30:0], 1'b0} : a_q;
                    if (cnt_q == 5'd31) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = op_result;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            funct3_q <= 3'd0;
            rd_q     <= 5'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            neg_q    <= 1'b0;
            sign_a_q <= 1'b0;
            acc_q    <= 64'd0;
            rem_q    <= 33'd0;
            quo_q    <= 32'd0;
            result_q <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            rd_q     <= rd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            sign_a_q <= sign_a_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // Stall is combinational so the E stage freezes in the accept cycle.
    assign bus.stall_o  = ((state_q == IDLE) && bus.start && !bus.flush) ||
                          (state_q == BUSY);
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;
    assign bus.rd_o     = rd_q;
endmodule
